// File: rtl/sda_kernel_go_arbiter.sv
// sda_kernel_go_arbiter
// Shares one kernel go/done control path between NumReq requesters.
// Go requests are arbitrated round-robin, the winner's go is forwarded to the
// reset handler, and the done response is routed back to that requester.
// Only one kernel run is outstanding at a time.
// Optional watchdog recovery of a hung kernel: define SDA_KERNEL_WATCHDOG_EN.
module sda_kernel_go_arbiter #(
   parameter int NumReq            = 4,
   parameter int IdWidth           = 2,
   parameter int WatchdogCountSize = 24,
   parameter int RecoverCountSize  = 6
) (
   input  logic               clk,
   input  logic               rstN,
   input  logic [NumReq-1:0]  reqGoValid,
   output logic [NumReq-1:0]  reqGoHoldoff,
   output logic [NumReq-1:0]  reqDoneValid,
   input  logic [NumReq-1:0]  reqDoneStop,
   output logic               reqDoneError,
   output logic               regGoValid,
   input  logic               regGoHoldoff,
   input  logic               regDoneValid,
   output logic               regDoneStop,
   output logic               sysRstReq,
   output logic [IdWidth-1:0] grantId,
   output logic               busy
);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StRunning,
`ifdef SDA_KERNEL_WATCHDOG_EN
      StRecover,
`endif
      StRespond
   } state_e;

   state_e             state_q;
   logic [IdWidth-1:0] rrPtr_q;
   logic [IdWidth-1:0] grantId_q;
   logic               regGoValid_q;
   logic               regDoneStop_q;
   logic [NumReq-1:0]  reqDoneValid_q;
   logic               busy_q;

`ifdef SDA_KERNEL_WATCHDOG_EN
   logic [WatchdogCountSize-1:0] wdCnt_q;
   logic [RecoverCountSize-1:0]  recCnt_q;
   logic                         sysRstReq_q;
   logic                         reqDoneError_q;
`endif

   logic [NumReq-1:0]  rotReq;
   logic               winFound;
   logic [IdWidth-1:0] winId_d;
   logic [NumReq-1:0]  winOneHot;
   logic [NumReq-1:0]  grantOneHot;
   logic [IdWidth-1:0] rrPtr_d;
   logic               grantedStop;

   // Round-robin search: rotate requests so rrPtr sits at bit 0, take the
   // lowest set bit, then map the offset back to a requester index.
   always_comb begin
      int idx;
      rotReq    = (reqGoValid >> rrPtr_q) | (reqGoValid << (NumReq - int'(rrPtr_q)));
      winFound  = 1'b0;
      idx       = 0;
      for (int k = 0; k < NumReq; k++) begin
         if (!winFound && rotReq[k]) begin
            winFound = 1'b1;
            idx      = int'(rrPtr_q) + k;
            if (idx >= NumReq) begin
               idx = idx - NumReq;
            end
         end
      end
      winId_d   = IdWidth'(idx);
      winOneHot = NumReq'(1) << idx;
   end

   // Only the winner sees its holdoff drop, and only while idle.
   always_comb begin
      reqGoHoldoff = '1;
      if (state_q == StIdle && winFound) begin
         reqGoHoldoff = ~winOneHot;
      end
   end

   // Helpers for the respond path: grant decode, stop of the granted
   // requester, and the pointer value after a completed run.
   always_comb begin
      grantOneHot = NumReq'(1) << grantId_q;
      grantedStop = |(reqDoneStop & reqDoneValid_q);
      rrPtr_d     = (grantId_q == IdWidth'(NumReq - 1)) ? '0 : grantId_q + 1'b1;
   end

   // Main control FSM; every output except reqGoHoldoff is a register here.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q        <= StIdle;
         rrPtr_q        <= '0;
         grantId_q      <= '0;
         regGoValid_q   <= 1'b0;
         regDoneStop_q  <= 1'b1;
         reqDoneValid_q <= '0;
         busy_q         <= 1'b0;
`ifdef SDA_KERNEL_WATCHDOG_EN
         wdCnt_q        <= '0;
         recCnt_q       <= '0;
         sysRstReq_q    <= 1'b0;
         reqDoneError_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (winFound) begin
                  grantId_q    <= winId_d;
                  regGoValid_q <= 1'b1;
                  busy_q       <= 1'b1;
                  state_q      <= StIssue;
`ifdef SDA_KERNEL_WATCHDOG_EN
                  wdCnt_q      <= '0;
`endif
               end
            end

            StIssue: begin
`ifdef SDA_KERNEL_WATCHDOG_EN
               wdCnt_q <= wdCnt_q + 1'b1;
               if (&wdCnt_q) begin
                  // The pending go is moot once the system reset is requested.
                  sysRstReq_q   <= 1'b1;
                  regGoValid_q  <= 1'b0;
                  regDoneStop_q <= 1'b1;
                  recCnt_q      <= '0;
                  state_q       <= StRecover;
               end else if (!regGoHoldoff) begin
                  regGoValid_q  <= 1'b0;
                  regDoneStop_q <= 1'b0;
                  state_q       <= StRunning;
               end
`else
               if (!regGoHoldoff) begin
                  regGoValid_q  <= 1'b0;
                  regDoneStop_q <= 1'b0;
                  state_q       <= StRunning;
               end
`endif
            end

            StRunning: begin
`ifdef SDA_KERNEL_WATCHDOG_EN
               // A done arriving on the expiry cycle was accepted by the
               // handler, so it wins over the timeout.
               if (regDoneValid) begin
                  regDoneStop_q  <= 1'b1;
                  reqDoneError_q <= 1'b0;
                  reqDoneValid_q <= grantOneHot;
                  state_q        <= StRespond;
               end else if (&wdCnt_q) begin
                  sysRstReq_q    <= 1'b1;
                  regDoneStop_q  <= 1'b1;
                  recCnt_q       <= '0;
                  state_q        <= StRecover;
               end else begin
                  wdCnt_q        <= wdCnt_q + 1'b1;
               end
`else
               if (regDoneValid) begin
                  regDoneStop_q  <= 1'b1;
                  reqDoneValid_q <= grantOneHot;
                  state_q        <= StRespond;
               end
`endif
            end

`ifdef SDA_KERNEL_WATCHDOG_EN
            StRecover: begin
               sysRstReq_q <= 1'b0;
               recCnt_q    <= recCnt_q + 1'b1;
               if (&recCnt_q) begin
                  reqDoneValid_q <= grantOneHot;
                  reqDoneError_q <= 1'b1;
                  state_q        <= StRespond;
               end
            end
`endif

            StRespond: begin
               if (!grantedStop) begin
                  reqDoneValid_q <= '0;
                  rrPtr_q        <= rrPtr_d;
                  busy_q         <= 1'b0;
                  state_q        <= StIdle;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign regGoValid   = regGoValid_q;
   assign regDoneStop  = regDoneStop_q;
   assign reqDoneValid = reqDoneValid_q;
   assign grantId      = grantId_q;
   assign busy         = busy_q;

`ifdef SDA_KERNEL_WATCHDOG_EN
   assign sysRstReq    = sysRstReq_q;
   assign reqDoneError = reqDoneError_q;
`else
   // Without the watchdog a run can never be aborted.
   logic unusedCfg;
   assign unusedCfg    = ^{WatchdogCountSize, RecoverCountSize};
   assign sysRstReq    = 1'b0;
   assign reqDoneError = 1'b0;
`endif

endmodule

// File: tb/tb_sda_kernel_go_arbiter.sv
// Testbench for sda_kernel_go_arbiter.
// Directed stimulus; expected done responses are queued when requests are
// issued and popped by a monitor whenever a done transfer is presented.
module tb_sda_kernel_go_arbiter;

   localparam int NumReq = 4;

   typedef struct {
      logic [1:0] id;
      logic       err;
   } exp_t;

   logic              clk;
   logic              rstN;
   logic [NumReq-1:0] reqGoValid;
   logic [NumReq-1:0] reqGoHoldoff;
   logic [NumReq-1:0] reqDoneValid;
   logic [NumReq-1:0] reqDoneStop;
   logic              reqDoneError;
   logic              regGoValid;
   logic              regGoHoldoff;
   logic              regDoneValid;
   logic              regDoneStop;
   logic              sysRstReq;
   logic [1:0]        grantId;
   logic              busy;

   int   checks = 0;
   int   errors = 0;
   exp_t expQ[$];
   int   reqIssued[NumReq];
   int   reqServed[NumReq];
   logic [NumReq-1:0] accMask;

   sda_kernel_go_arbiter #(
      .NumReq(NumReq),
      .IdWidth(2),
      .WatchdogCountSize(4),
      .RecoverCountSize(6)
   ) dut (
      .clk(clk),
      .rstN(rstN),
      .reqGoValid(reqGoValid),
      .reqGoHoldoff(reqGoHoldoff),
      .reqDoneValid(reqDoneValid),
      .reqDoneStop(reqDoneStop),
      .reqDoneError(reqDoneError),
      .regGoValid(regGoValid),
      .regGoHoldoff(regGoHoldoff),
      .regDoneValid(regDoneValid),
      .regDoneStop(regDoneStop),
      .sysRstReq(sysRstReq),
      .grantId(grantId),
      .busy(busy)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // A requester keeps its go valid until accepted; issue/serve counters keep
   // the two writers separate.
   always_comb begin
      for (int i = 0; i < NumReq; i++) begin
         reqGoValid[i] = (reqIssued[i] != reqServed[i]);
      end
   end

   // Drop each requester's go right after the edge on which it was accepted.
   initial begin
      accMask = '0;
      forever begin
         @(negedge clk);
         accMask = reqGoValid & ~reqGoHoldoff;
         @(posedge clk);
         #1;
         for (int i = 0; i < NumReq; i++) begin
            if (accMask[i]) reqServed[i]++;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Monitor: every done transfer is matched against the oldest expectation.
   always @(negedge clk) begin
      logic [NumReq-1:0] xfer;
      exp_t e;
      xfer = reqDoneValid & ~reqDoneStop;
      if (rstN && xfer != '0) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedDone: got reqDoneValid=%b, required no done", reqDoneValid);
         end else begin
            e = expQ.pop_front();
            checkOutput("doneVector", 32'(xfer), 32'(4'b0001 << e.id));
            checkOutput("doneGrantId", 32'(grantId), 32'(e.id));
            checkOutput("doneError", 32'(reqDoneError), 32'(e.err));
         end
      end
   end

   task automatic pushExp(input logic [1:0] id, input logic err);
      exp_t e;
      e.id  = id;
      e.err = err;
      expQ.push_back(e);
   endtask

   task automatic applyStimulus(input logic [NumReq-1:0] newReq, input logic goHoldoff,
                                input logic doneValid, input logic [NumReq-1:0] doneStop);
      @(posedge clk);
      #3;
      for (int i = 0; i < NumReq; i++) begin
         if (newReq[i]) reqIssued[i]++;
      end
      regGoHoldoff = goHoldoff;
      regDoneValid = doneValid;
      reqDoneStop  = doneStop;
   endtask

   task automatic hold();
      @(posedge clk);
      #3;
   endtask

   task automatic waitDrain(input int maxCycles);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < maxCycles) begin
         @(negedge clk);
         n++;
      end
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drainTimeout: got %0d pending responses, required 0", expQ.size());
         expQ.delete();
      end
   endtask

   task automatic doReset();
      hold();
      rstN = 1'b0;
      hold();
      hold();
      rstN = 1'b1;
   endtask

   initial begin
      int  dt;
      bit  found;
      bit  sawRst;
      for (int i = 0; i < NumReq; i++) begin
         reqIssued[i] = 0;
         reqServed[i] = 0;
      end
      rstN         = 1'b0;
      regGoHoldoff = 1'b1;
      regDoneValid = 1'b0;
      reqDoneStop  = '0;
      repeat (3) @(posedge clk);
      #3;

      // Reset values
      checkOutput("rstRegGoValid", 32'(regGoValid), 32'd0);
      checkOutput("rstRegDoneStop", 32'(regDoneStop), 32'd1);
      checkOutput("rstReqDoneValid", 32'(reqDoneValid), 32'd0);
      checkOutput("rstReqDoneError", 32'(reqDoneError), 32'd0);
      checkOutput("rstSysRstReq", 32'(sysRstReq), 32'd0);
      checkOutput("rstGrantId", 32'(grantId), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstHoldoff", 32'(reqGoHoldoff), 32'hf);
      rstN = 1'b1;

      // Single requester, full handshake sequence
      $display("[TB] single request");
      applyStimulus(4'b0001, 1'b1, 1'b0, 4'b0000);
      pushExp(2'd0, 1'b0);
      @(negedge clk);
      checkOutput("t1HoldoffSameCycle", 32'(reqGoHoldoff), 32'he);
      hold();
      @(negedge clk);
      checkOutput("t1RegGoValid", 32'(regGoValid), 32'd1);
      checkOutput("t1GrantId", 32'(grantId), 32'd0);
      checkOutput("t1Busy", 32'(busy), 32'd1);
      checkOutput("t1HoldoffAfter", 32'(reqGoHoldoff), 32'hf);
      applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0000);
      @(negedge clk);
      checkOutput("t1GoStillValid", 32'(regGoValid), 32'd1);
      applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);
      @(negedge clk);
      checkOutput("t1RunGoValid", 32'(regGoValid), 32'd0);
      checkOutput("t1RunDoneStop", 32'(regDoneStop), 32'd0);
      applyStimulus(4'b0000, 1'b1, 1'b1, 4'b0000);
      applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);
      @(negedge clk);
      checkOutput("t1DoneLatency", 32'(reqDoneValid), 32'h1);
      checkOutput("t1DoneStopBack", 32'(regDoneStop), 32'd1);
      waitDrain(20);

      // Round-robin order from a fresh reset with an instantly-done kernel
      $display("[TB] round robin");
      doReset();
      applyStimulus(4'b1111, 1'b0, 1'b1, 4'b0000);
      pushExp(2'd0, 1'b0);
      pushExp(2'd1, 1'b0);
      pushExp(2'd2, 1'b0);
      pushExp(2'd3, 1'b0);
      waitDrain(80);
      applyStimulus(4'b0101, 1'b0, 1'b1, 4'b0000);
      pushExp(2'd0, 1'b0);
      pushExp(2'd2, 1'b0);
      waitDrain(60);

      // Go holdoff and done backpressure (pointer now at 3)
      $display("[TB] backpressure");
      applyStimulus(4'b0001, 1'b1, 1'b0, 4'b0000);
      pushExp(2'd0, 1'b0);
      hold();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput("t3GoHeld", 32'(regGoValid), 32'd1);
         hold();
      end
      applyStimulus(4'b0000, 1'b0, 1'b0, 4'b0001);
      applyStimulus(4'b0000, 1'b1, 1'b1, 4'b0001);
      applyStimulus(4'b0010, 1'b1, 1'b0, 4'b0001);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("t3DoneHeld", 32'(reqDoneValid), 32'h1);
         checkOutput("t3NoRegrant", 32'(grantId), 32'd0);
         checkOutput("t3NoNewGo", 32'(regGoValid), 32'd0);
         checkOutput("t3HoldoffAll", 32'(reqGoHoldoff), 32'hf);
         hold();
      end
      applyStimulus(4'b0000, 1'b0, 1'b1, 4'b0000);
      pushExp(2'd1, 1'b0);
      waitDrain(40);

      // Asynchronous reset mid-run (pointer now at 2)
      $display("[TB] reset mid-run");
      applyStimulus(4'b0001, 1'b0, 1'b0, 4'b0000);
      hold();
      applyStimulus(4'b0000, 1'b1, 1'b0, 4'b0000);
      @(negedge clk);
      checkOutput("t4Running", 32'(regDoneStop), 32'd0);
      hold();
      rstN = 1'b0;
      #1;
      checkOutput("t4AsyncDoneStop", 32'(regDoneStop), 32'd1);
      checkOutput("t4AsyncBusy", 32'(busy), 32'd0);
      checkOutput("t4AsyncGoValid", 32'(regGoValid), 32'd0);
      checkOutput("t4AsyncSysRst", 32'(sysRstReq), 32'd0);
      hold();
      rstN = 1'b1;
      applyStimulus(4'b1010, 1'b1, 1'b0, 4'b0000);
      @(negedge clk);
      checkOutput("t4PtrRestart", 32'(reqGoHoldoff), 32'hd);
      pushExp(2'd1, 1'b0);
      pushExp(2'd3, 1'b0);
      applyStimulus(4'b0000, 1'b0, 1'b1, 4'b0000);
      waitDrain(60);
      applyStimulus(4'b0100, 1'b0, 1'b1, 4'b0000);
      pushExp(2'd2, 1'b0);
      @(negedge clk);
      checkOutput("t4Holdoff2", 32'(reqGoHoldoff), 32'hb);
      hold();
      @(negedge clk);
      checkOutput("t4GrantId2", 32'(grantId), 32'd2);
      waitDrain(30);

`ifdef SDA_KERNEL_WATCHDOG_EN
      // Watchdog expiry and recovery
      $display("[TB] watchdog");
      applyStimulus(4'b0001, 1'b0, 1'b0, 4'b0000);
      pushExp(2'd0, 1'b1);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (regGoValid) found = 1'b1;
      end
      checkOutput("t5IssueSeen", 32'(found), 32'd1);
      dt    = 0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         dt++;
         if (sysRstReq) found = 1'b1;
      end
      checkOutput("t5WatchdogDelay", 32'(dt), 32'd16);
      @(negedge clk);
      checkOutput("t5RstPulseWidth", 32'(sysRstReq), 32'd0);
      checkOutput("t5RecoverStop", 32'(regDoneStop), 32'd1);
      dt    = 1;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         dt++;
         if (reqDoneValid != '0) found = 1'b1;
      end
      checkOutput("t5RecoverDelay", 32'(dt), 32'd64);
      waitDrain(20);
      sawRst = 1'b0;
`else
      // No watchdog: a missing done keeps the run open indefinitely
      $display("[TB] no watchdog");
      applyStimulus(4'b0001, 1'b0, 1'b0, 4'b0000);
      pushExp(2'd0, 1'b0);
      sawRst = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         if (sysRstReq) sawRst = 1'b1;
      end
      checkOutput("t6NoSysRst", 32'(sawRst), 32'd0);
      checkOutput("t6Busy", 32'(busy), 32'd1);
      checkOutput("t6StillRunning", 32'(regDoneStop), 32'd0);
      applyStimulus(4'b0000, 1'b0, 1'b1, 4'b0000);
      waitDrain(20);
      dt    = 0;
      found = 1'b0;
`endif

      hold();
      checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
